sorted_ram_loader: RTL and testbench

//  Write side of the 32x8 sorted lookup RAM: accepts bytes over a valid/ready handshake and

---
 rtl/sorted_ram_pkg.sv | 15 +
 rtl/sorted_ram_loader.sv | 100 ++++++++++
 tb/tb_sorted_ram_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sorted_ram_pkg.sv
// rtl/sorted_ram_pkg.sv - shared sizes and loader state encoding for the sorted lookup RAM
package sorted_ram_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CMP,
        S_PLACE
    } state_e;

endpackage

// File: rtl/sorted_ram_loader.sv
// rtl/sorted_ram_loader.sv - insertion-sort write side of the 32x8 sorted lookup RAM
module sorted_ram_loader
    import sorted_ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_wren_o,
    input  logic [DATA_W-1:0] ram_q_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [ADDR_W:0]     count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign full_o     = (count_q == FULL_COUNT);
    assign busy_o     = (state_q != S_IDLE);
    assign in_ready_o = (state_q == S_IDLE) && !full_o && enable_i && !clear_i;

    // RAM outputs are decoded from state so an async reset drops wren in the same cycle
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        count_d     = count_q;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wren_o  = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i && clear_i) begin
                    count_d = '0;
                end else if (in_ready_o && in_valid_i) begin
                    x_d     = in_data_i;
                    idx_d   = count_q[ADDR_W-1:0];
                    state_d = (count_q == '0) ? S_PLACE : S_READ;
                end
            end
            S_READ: begin
                ram_addr_o = idx_q - 1'b1;
                if (enable_i) state_d = S_CMP;
            end
            S_CMP: begin
                ram_addr_o = idx_q;
                // A freeze here may let ram_q go stale, so the neighbour is fetched again
                if (!enable_i) begin
                    state_d = S_READ;
                end else if (ram_q_i > x_q) begin
                    ram_wdata_o = ram_q_i;
                    ram_wren_o  = 1'b1;
                    idx_d       = idx_q - 1'b1;
                    state_d     = (idx_q == ADDR_W'(1)) ? S_PLACE : S_READ;
                end else begin
                    state_d = S_PLACE;
                end
            end
            S_PLACE: begin
                ram_addr_o  = idx_q;
                ram_wdata_o = x_q;
                if (enable_i) begin
                    ram_wren_o = 1'b1;
                    done_o     = 1'b1;
                    count_d    = count_q + 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sorted_ram_loader.sv
// tb/tb_sorted_ram_loader.sv - self-checking bench for sorted_ram_loader with a behavioural RAM
module tb_sorted_ram_loader;
    import sorted_ram_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic              ram_wren_o;
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W:0]   count_o;
    logic              full_o;
    logic              busy_o;
    logic              done_o;

    logic [DATA_W-1:0] mem [DEPTH];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        chk_en  = 1'b0;
    int          mdl_count = 0;
    logic [7:0]  mdl_q[$];

    always #5 clk = ~clk;

    sorted_ram_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_wren_o  (ram_wren_o),
        .ram_q_i     (ram_q),
        .count_o     (count_o),
        .full_o      (full_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always @(posedge clk) begin
        if (ram_wren_o) mem[ram_addr_o] <= ram_wdata_o;
        ram_q <= mem[ram_addr_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("count", count_o, mdl_count);
            check("full", full_o, (mdl_count == DEPTH));
        end
    end

    // Expected latency comes from the sorted-list position and the shift count, not the FSM
    task automatic insert(input logic [7:0] x, input int lit_lat, input int lit_addr,
                          input int frz_at, input int frz_len);
        int n, k, pos, exp_lat, got_lat, got_addr, waitc;
        n   = mdl_q.size();
        pos = 0;
        for (int j = 0; j < n; j++) if (mdl_q[j] <= x) pos++;
        k = n - pos;
        exp_lat = (n == 0) ? 1 : ((k == n) ? 2 * k + 1 : 2 * k + 3);
        if (frz_len > 0)
            exp_lat = exp_lat + frz_len + (((frz_at % 2) == 0 && frz_at < exp_lat) ? 1 : 0);
        if (lit_lat >= 0) check("lat_literal", exp_lat, lit_lat);
        if (lit_addr >= 0) check("addr_literal", pos, lit_addr);

        waitc = 0;
        @(negedge clk);
        while (!in_ready_o && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("in_ready_before_accept", in_ready_o, 1);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        got_lat  = 0;
        got_addr = -1;
        for (int c = 1; c <= 80; c++) begin
            if (c == frz_at) enable = 1'b0;
            if (c == frz_at + frz_len) enable = 1'b1;
            @(negedge clk);
            if (!enable) check("frozen_wren_done", {ram_wren_o, done_o}, 0);
            if (done_o) begin
                got_lat  = c;
                got_addr = ram_addr_o;
                break;
            end
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        check("done_latency", got_lat, exp_lat);
        check("place_addr", got_addr, pos);
        mdl_q.insert(pos, x);
        @(posedge clk);
        #1;
        mdl_count++;
        for (int j = 0; j < mdl_q.size(); j++) check("mem", mem[j], mdl_q[j]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp2 [4];
        logic [7:0] exp6 [7];
        exp2 = '{8'd3, 8'd5, 8'd7, 8'd10};
        exp6 = '{8'd3, 8'd5, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10};
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        for (int j = 0; j < DEPTH; j++) mem[j] = 8'hxx;
        #12;
        check("rst_count", count_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_wren", ram_wren_o, 0);
        check("rst_addr", ram_addr_o, 0);
        check("rst_wdata", ram_wdata_o, 0);
        check("rst_done", done_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready_o, 1);

        // Test 1 and 2: basic ordering, bottom-reaching and compare-stopped inserts
        insert(8'd5, 1, 0, 0, 0);
        insert(8'd10, 3, 1, 0, 0);
        insert(8'd3, 5, 0, 0, 0);
        insert(8'd7, 5, 2, 0, 0);
        for (int j = 0; j < 4; j++) check("mem_literal_t2", mem[j], exp2[j]);

        // Test 3: duplicate lands above the existing equal value
        insert(8'd5, 7, 2, 0, 0);

        // Test 6: freeze in S_CMP (re-read) and in S_READ
        insert(8'd6, 11, 3, 2, 3);
        insert(8'd8, 8, 5, 1, 3);
        for (int j = 0; j < 7; j++) check("mem_literal_t6", mem[j], exp6[j]);

        // Test 5: async reset while a shift write is being driven
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("cmp_wren_before_reset", ram_wren_o, 1);
        rst_n = 1'b0;
        mdl_count = 0;
        mdl_q.delete();
        #1;
        check("reset_wren_same_cycle", ram_wren_o, 0);
        check("reset_count", count_o, 0);
        check("reset_busy", busy_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_release", in_ready_o, 1);

        // Clear beats a simultaneous In_valid
        insert(8'd50, 1, 0, 0, 0);
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd9;
        #1;
        check("clear_blocks_ready", in_ready_o, 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        mdl_count = 0;
        mdl_q.delete();
        @(negedge clk);
        check("clear_no_accept", busy_o, 0);

        // Test 4: fill with descending values, every insert shifts to the bottom
        for (int i = 0; i < DEPTH; i++) insert(8'(255 - i), 2 * i + 1, 0, 0, 0);
        for (int j = 0; j < DEPTH; j++) check("mem_literal_t4", mem[j], 224 + j);
        @(negedge clk);
        check("full_flag", full_o, 1);
        check("full_in_ready", in_ready_o, 0);
        in_valid = 1'b1;
        in_data  = 8'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("full_ignore_ready", in_ready_o, 0);
            check("full_ignore_busy", busy_o, 0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("full_count_held", count_o, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
